// File: rtl/div_arbiter_if.sv
// Handshake/result bundle shared by the two requesters and div_arbiter.
//   req0/req1              : level requests, held until granted
//   dividend*/divisor*     : operands of requester 0/1
//   gnt0/gnt1              : one-cycle pulse, operands captured
//   done0/done1            : result valid for owner, held until acked
//   done_ack0/done_ack1    : owner has consumed the result
//   quotient/remainder     : shared result, div_by_zero flags divisor 0
//   busy                   : arbiter not idle
interface div_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] dividend0;
  logic [WIDTH-1:0] divisor0;
  logic [WIDTH-1:0] dividend1;
  logic [WIDTH-1:0] divisor1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             done_ack0;
  logic             done_ack1;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport slave (
    input  req0, req1, dividend0, divisor0, dividend1, divisor1,
           done_ack0, done_ack1,
    output gnt0, gnt1, done0, done1, quotient, remainder, div_by_zero, busy
  );

  modport master (
    output req0, req1, dividend0, divisor0, dividend1, divisor1,
           done_ack0, done_ack1,
    input  gnt0, gnt1, done0, done1, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared unsigned restoring divider.
//   clock   : sole clock, posedge
//   reset_n : asynchronous active-low reset
//   div_if  : div_arbiter_if slave modport (requests, operands, grants,
//             done/ack handshake, shared quotient/remainder/div_by_zero, busy)
// One quotient bit per ITER cycle, MSB first; result registers only change on
// entry to DONE, so they hold the last result while idle.
module div_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  div_arbiter_if.slave  div_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;      // tie-break winner: 0 -> requester 0
  logic             r_owner;
  logic             r_dz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_grant;
  logic             w_win1;
  logic             w_ack;
  logic             w_ge;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win1      = 1'b0;
    w_ack       = 1'b0;
    // WIDTH+1-bit trial remainder keeps the bit shifted out of r_rem.
    w_trial     = {r_rem, r_quo[WIDTH-1]};
    w_ge        = (w_trial >= {1'b0, r_dvs});
    // Only used when w_ge, where the true difference fits in WIDTH bits.
    w_diff      = w_trial[WIDTH-1:0] - r_dvs;
    case (r_state)
      IDLE: begin
        if (div_if.req0 || div_if.req1) begin
          w_grant     = 1'b1;
          w_win1      = div_if.req1 & (~div_if.req0 | r_ptr);
          w_state_nxt = ITER;
        end
      end
      ITER: begin
        if (r_dz || (r_cnt == LAST)) w_state_nxt = DONE;
      end
      DONE: begin
        w_ack = r_owner ? div_if.done_ack1 : div_if.done_ack0;
        if (w_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ptr         <= 1'b0;
      r_owner       <= 1'b0;
      r_dz          <= 1'b0;
      r_cnt         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_rem         <= '0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_win1;
            r_gnt0  <= ~w_win1;
            r_gnt1  <= w_win1;
            r_quo   <= w_win1 ? div_if.dividend1 : div_if.dividend0;
            r_dvs   <= w_win1 ? div_if.divisor1  : div_if.divisor0;
            r_dz    <= w_win1 ? (div_if.divisor1 == '0) : (div_if.divisor0 == '0);
            r_rem   <= '0;
            r_cnt   <= '0;
            // Pointer only moves on contention, away from the winner.
            if (div_if.req0 && div_if.req1) r_ptr <= ~w_win1;
          end
        end
        ITER: begin
          // Divide-by-zero spends a single ITER cycle so done lands one edge
          // after the grant, never overlapping the gnt pulse.
          if (r_dz) begin
            r_quotient    <= '1;
            r_remainder   <= r_quo;
            r_div_by_zero <= 1'b1;
            r_done0       <= ~r_owner;
            r_done1       <= r_owner;
          end else if (r_cnt == LAST) begin
            r_quotient    <= r_quo;
            r_remainder   <= r_rem;
            r_div_by_zero <= 1'b0;
            r_done0       <= ~r_owner;
            r_done1       <= r_owner;
          end else begin
            r_rem <= w_ge ? w_diff : w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (w_ack) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_if.gnt0        = r_gnt0;
  assign div_if.gnt1        = r_gnt1;
  assign div_if.done0       = r_done0;
  assign div_if.done1       = r_done1;
  assign div_if.quotient    = r_quotient;
  assign div_if.remainder   = r_remainder;
  assign div_if.div_by_zero = r_div_by_zero;
  assign div_if.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;
  localparam int unsigned W = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  div_arbiter_if #(.WIDTH(W)) bif ();

  div_arbiter #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .div_if  (bif.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic         who;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic         who;
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  exp_t         sbq[$];
  vec_t         tbl[8];
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  logic         last_dz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic submit(input logic who, input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                        input bit push);
    exp_t e;
    if (who) begin
      bif.dividend1 = dd; bif.divisor1 = dv; bif.req1 = 1'b1;
    end else begin
      bif.dividend0 = dd; bif.divisor0 = dv; bif.req0 = 1'b1;
    end
    if (push) begin
      e.who = who; e.q = q; e.r = r; e.dz = dz;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_gnt(input logic who, output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bif.gnt0 || bif.gnt1) begin
        t = cyc;
        break;
      end
    end
    check("grant_seen", 32'(t >= 0), 32'd1);
    if (t >= 0) check("grant_owner", {30'd0, bif.gnt1, bif.gnt0}, who ? 32'd2 : 32'd1);
    if (who) bif.req1 = 1'b0; else bif.req0 = 1'b0;
  endtask

  task automatic wait_done(input logic who, input int t_g);
    exp_t e;
    int   t     = -1;
    int   stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (who ? bif.done1 : bif.done0) begin
        t = cyc;
        break;
      end
      if (bif.gnt0 || bif.gnt1 || bif.done0 || bif.done1 || !bif.busy) stray++;
    end
    check("done_seen", 32'(t >= 0), 32'd1);
    check("no_stray_during_iter", 32'(stray), 32'd0);
    if (sbq.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      last_q = e.q; last_r = e.r; last_dz = e.dz;
      if (t >= 0) begin
        check("done_owner", 32'(e.who), 32'(who));
        check("done_latency", 32'(t - t_g), e.dz ? 32'd1 : 32'(W + 1));
        check("quotient", 32'(bif.quotient), 32'(e.q));
        check("remainder", 32'(bif.remainder), 32'(e.r));
        check("div_by_zero", 32'(bif.div_by_zero), 32'(e.dz));
        check("other_done_low", 32'(who ? bif.done0 : bif.done1), 32'd0);
        check("busy_in_done", 32'(bif.busy), 32'd1);
      end
    end
  endtask

  task automatic do_ack(input logic who, output int t_ack);
    if (who) bif.done_ack1 = 1'b1; else bif.done_ack0 = 1'b1;
    t_ack = cyc + 1;
    @(negedge clock);
    bif.done_ack0 = 1'b0;
    bif.done_ack1 = 1'b0;
    check("done_cleared", {30'd0, bif.done1, bif.done0}, 32'd0);
    check("idle_after_ack", 32'(bif.busy), 32'd0);
    check("held_quotient", 32'(bif.quotient), 32'(last_q));
    check("held_remainder", 32'(bif.remainder), 32'(last_r));
    check("held_dz", 32'(bif.div_by_zero), 32'(last_dz));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {30'd0, bif.gnt1, bif.gnt0}, 32'd0);
    check({tag, "_done"}, {30'd0, bif.done1, bif.done0}, 32'd0);
    check({tag, "_busy"}, 32'(bif.busy), 32'd0);
    check({tag, "_dz"}, 32'(bif.div_by_zero), 32'd0);
    check({tag, "_quotient"}, 32'(bif.quotient), 32'd0);
    check({tag, "_remainder"}, 32'(bif.remainder), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, ta, rel;

    tbl[0] = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    tbl[1] = '{1'b1, 8'd55,  8'd0,   8'hFF,  8'h37, 1'b1};
    tbl[2] = '{1'b0, 8'd255, 8'd16,  8'd15,  8'd15, 1'b0};
    tbl[3] = '{1'b1, 8'd200, 8'd1,   8'd200, 8'd0,  1'b0};
    tbl[4] = '{1'b0, 8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    tbl[5] = '{1'b1, 8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
    tbl[6] = '{1'b0, 8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    tbl[7] = '{1'b1, 8'd129, 8'd2,   8'd64,  8'd1,  1'b0};

    bif.req0 = 1'b0; bif.req1 = 1'b0;
    bif.dividend0 = '0; bif.divisor0 = '0;
    bif.dividend1 = '0; bif.divisor1 = '0;
    bif.done_ack0 = 1'b0; bif.done_ack1 = 1'b0;

    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Single-requester vectors, including divide-by-zero and edge operands.
    for (int i = 0; i < 8; i++) begin
      submit(tbl[i].who, tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r, tbl[i].dz, 1'b1);
      wait_gnt(tbl[i].who, t);
      wait_done(tbl[i].who, t);
      do_ack(tbl[i].who, ta);
    end

    // Reset mid-operation aborts without done; first grant after release.
    submit(1'b0, 8'd255, 8'd16, 8'd0, 8'd0, 1'b0, 1'b0);
    wait_gnt(1'b0, t);
    while (cyc < t + 3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clock);
    @(negedge clock);
    check("abort_no_done", {30'd0, bif.done1, bif.done0}, 32'd0);
    reset_n = 1'b1;
    rel = cyc;
    submit(1'b0, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b1);
    wait_gnt(1'b0, t);
    check("first_grant_after_reset", 32'(t - rel), 32'd1);
    wait_done(1'b0, t);
    do_ack(1'b0, ta);

    // Contention right after reset: requester 0, then 1; then 1 wins the rematch.
    for (int round = 0; round < 2; round++) begin
      logic first;
      first = (round == 1);
      if (first) begin
        submit(1'b1, 8'd5,   8'd9, 8'd0,   8'd5, 1'b0, 1'b1);
        submit(1'b0, 8'd200, 8'd1, 8'd200, 8'd0, 1'b0, 1'b1);
      end else begin
        submit(1'b0, 8'd200, 8'd1, 8'd200, 8'd0, 1'b0, 1'b1);
        submit(1'b1, 8'd5,   8'd9, 8'd0,   8'd5, 1'b0, 1'b1);
      end
      wait_gnt(first, t);
      wait_done(first, t);
      do_ack(first, ta);
      wait_gnt(~first, t1);
      check("contention_spacing", 32'(t1 - ta), 32'd1);
      wait_done(~first, t1);
      do_ack(~first, ta);
    end

    // Non-owner ack in DONE is ignored.
    submit(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
    wait_gnt(1'b0, t);
    wait_done(1'b0, t);
    bif.done_ack1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("foreign_ack_done0", 32'(bif.done0), 32'd1);
      check("foreign_ack_busy", 32'(bif.busy), 32'd1);
      check("foreign_ack_q", 32'(bif.quotient), 32'd14);
      check("foreign_ack_r", 32'(bif.remainder), 32'd2);
    end
    bif.done_ack1 = 1'b0;
    do_ack(1'b0, ta);

    // req1 raised during ITER of requester 0; stray owner ack during ITER.
    submit(1'b0, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b1);
    wait_gnt(1'b0, t);
    @(negedge clock);
    submit(1'b1, 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 1'b1);
    bif.done_ack0 = 1'b1;
    @(negedge clock);
    bif.done_ack0 = 1'b0;
    wait_done(1'b0, t);
    do_ack(1'b0, ta);
    wait_gnt(1'b1, t1);
    check("pending_req_spacing", 32'(t1 - ta), 32'd1);
    wait_done(1'b1, t1);
    do_ack(1'b1, ta);

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
